alu_adder_arbiter: RTL and testbench

- Shares one 32-bit DSP-based adder/subtractor between two requesters: requester 0 is the execute-stage ALU and requester 1 is the branch-target/PC adder.
- Arbitrates requests round-robin, runs them through a 2-stage pipeline (operand register, then result register) at one op per cycle, and returns results on a single tagged response channel with backpressure.
- Sits between the decode/execute control and the iCE40 SB_MAC16 adder. It replaces per-requester adders to save DSP tiles.

---
 rtl/alu_adder_arbiter_pkg.sv | 18 +
 rtl/dsp_addsub32.sv | 34 +++
 rtl/alu_adder_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_adder_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_adder_arbiter_pkg.sv
// Shared constants and types for the shared ALU/branch adder and its DSP wrapper.
package alu_adder_arbiter_pkg;

  localparam int kALU_ADDER_WIDTH = 32;

  localparam logic kALU_ADDER_REQ_ALU    = 1'b0;
  localparam logic kALU_ADDER_REQ_BRANCH = 1'b1;

  localparam logic kALU_ADDER_OP_ADD = 1'b0;
  localparam logic kALU_ADDER_OP_SUB = 1'b1;

  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
  } alu_adder_flags_t;

endpackage

// File: rtl/dsp_addsub32.sv
// Combinational add/sub in the SB_MAC16 32-bit adder arrangement: two 16-bit
// halves with the low-half carry chained into the high half (behavioural model).
module dsp_addsub32
  import alu_adder_arbiter_pkg::*;
#(
  parameter int WIDTH = kALU_ADDER_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int HALF = WIDTH / 2;

  logic            inv;
  logic [HALF-1:0] b_lo;
  logic [HALF-1:0] b_hi;
  logic [HALF:0]   bot;
  logic [HALF:0]   top;

  // Subtract is A + ~B + 1: the +1 enters as the carry-in of the bottom adder.
  always_comb begin
    inv   = (sub == kALU_ADDER_OP_SUB);
    b_lo  = inv ? ~b[HALF-1:0] : b[HALF-1:0];
    b_hi  = inv ? ~b[WIDTH-1:HALF] : b[WIDTH-1:HALF];
    bot   = {1'b0, a[HALF-1:0]} + {1'b0, b_lo} + {{HALF{1'b0}}, inv};
    top   = {1'b0, a[WIDTH-1:HALF]} + {1'b0, b_hi} + {{HALF{1'b0}}, bot[HALF]};
    sum   = {top[HALF-1:0], bot[HALF-1:0]};
    carry = top[HALF];
  end

endmodule

// File: rtl/alu_adder_arbiter.sv
// Shares one DSP adder/subtractor between the execute ALU (id 0) and the
// branch-target adder (id 1): arbiter, two-stage pipeline, tagged response.
module alu_adder_arbiter
  import alu_adder_arbiter_pkg::*;
#(
  parameter int WIDTH      = kALU_ADDER_WIDTH,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_sub,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_sub,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_ovf
);

  logic             stall;
  logic             take;
  logic             gnt0;
  logic             gnt1;
  logic             gnt_id;
  logic             rr_ptr;
  logic             vld_p1;
  logic             vld_p2;
  logic             sub_p1;
  logic             id_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [WIDTH-1:0] sum_p1;
  logic             carry_p1;
  alu_adder_flags_t flags_p1;

  function automatic logic calc_zero(input logic [WIDTH-1:0] v);
    return (v == '0);
  endfunction

  // Operands of equal sign whose result sign differs have overflowed.
  function automatic logic calc_ovf(input logic a_msb, input logic b_eff_msb,
                                    input logic sum_msb);
    return (a_msb == b_eff_msb) && (sum_msb != a_msb);
  endfunction

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (FIXED_PRIO || (rr_ptr == kALU_ADDER_REQ_ALU)) gnt0 = 1'b1;
      else                                              gnt1 = 1'b1;
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
  end

  // Ready is gated by reset so nothing appears accepted while rst is held.
  assign stall      = vld_p2 & ~rsp_ready;
  assign take       = ~stall & ~rst;
  assign req0_ready = gnt0 & take;
  assign req1_ready = gnt1 & take;
  assign gnt_id     = gnt1 ? kALU_ADDER_REQ_BRANCH : kALU_ADDER_REQ_ALU;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      rr_ptr <= kALU_ADDER_REQ_ALU;
    end else if (!stall) begin
      vld_p2 <= vld_p1;
      vld_p1 <= gnt0 | gnt1;
      if (!FIXED_PRIO && req0_valid && req1_valid) rr_ptr <= ~gnt_id;
    end
  end

  // ---- stage p1: registered operands, op and requester id
  always_ff @(posedge clk) begin
    if (take && (gnt0 || gnt1)) begin
      a_p1   <= gnt1 ? req1_a : req0_a;
      b_p1   <= gnt1 ? req1_b : req0_b;
      sub_p1 <= gnt1 ? req1_sub : req0_sub;
      id_p1  <= gnt_id;
    end
  end

  dsp_addsub32 #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a     (a_p1),
    .b     (b_p1),
    .sub   (sub_p1),
    .sum   (sum_p1),
    .carry (carry_p1)
  );

  always_comb begin
    flags_p1.carry = carry_p1;
    flags_p1.zero  = calc_zero(sum_p1);
    flags_p1.ovf   = calc_ovf(a_p1[WIDTH-1],
                              (sub_p1 == kALU_ADDER_OP_SUB) ? ~b_p1[WIDTH-1] : b_p1[WIDTH-1],
                              sum_p1[WIDTH-1]);
  end

  // ---- stage p2: registered result and flags drive the response channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else if (!stall && vld_p1) begin
      rsp_id    <= id_p1;
      rsp_data  <= sum_p1;
      rsp_carry <= flags_p1.carry;
      rsp_zero  <= flags_p1.zero;
      rsp_ovf   <= flags_p1.ovf;
    end
  end

  assign rsp_valid = vld_p2;

endmodule

// File: tb/tb_alu_adder_arbiter.sv
// Testbench for alu_adder_arbiter: directed scenarios plus random traffic
// against an arithmetic reference model and a scoreboard of expected responses.
module tb_alu_adder_arbiter;
  import alu_adder_arbiter_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic          id;
    logic [W-1:0]  data;
    logic          carry;
    logic          zero;
    logic          ovf;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req0_sub = 1'b0, req0_ready;
  logic req1_valid = 1'b0, req1_sub = 1'b0, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_carry, rsp_zero, rsp_ovf;
  logic [W-1:0] rsp_data;
  logic fp0_valid = 1'b0, fp1_valid = 1'b0, fp0_ready, fp1_ready;
  logic fp_rsp_valid, fp_rsp_ready = 1'b1, fp_rsp_id, fp_rsp_carry, fp_rsp_zero, fp_rsp_ovf;
  logic [W-1:0] fp_rsp_data;

  int checks = 0;
  int errors = 0;

  // Reference model state: occupancy of the two stages, arbitration pointer,
  // payload waiting in stage 1 and the value the response outputs hold.
  logic m_v1 = 1'b0, m_v2 = 1'b0, m_rr = 1'b0;
  rsp_t m_p1 = '0, m_last = '0;

  always #5 clk = ~clk;

  alu_adder_arbiter #(.WIDTH(W), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_sub(req0_sub), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_sub(req1_sub), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf)
  );

  alu_adder_arbiter #(.WIDTH(W), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(fp0_valid), .req0_sub(req0_sub), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(fp0_ready),
    .req1_valid(fp1_valid), .req1_sub(req1_sub), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(fp1_ready),
    .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_id(fp_rsp_id), .rsp_data(fp_rsp_data),
    .rsp_carry(fp_rsp_carry), .rsp_zero(fp_rsp_zero), .rsp_ovf(fp_rsp_ovf)
  );

  function automatic rsp_t mk(input logic id, input logic [W-1:0] d, input logic c,
                              input logic z, input logic o);
    rsp_t r;
    r.id = id; r.data = d; r.carry = c; r.zero = z; r.ovf = o;
    return r;
  endfunction

  // Plain integer arithmetic: unsigned range for carry, signed range for overflow.
  function automatic rsp_t ref_op(input logic id, input logic sub, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
    rsp_t r;
    longint ua, ub, sa, sb, sres;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    r.id = id;
    if (sub) begin
      r.data  = 32'(ua - ub);
      r.carry = (ua >= ub);
      sres    = sa - sb;
    end else begin
      r.data  = 32'(ua + ub);
      r.carry = (ua + ub) > 64'sd4294967295;
      sres    = sa + sb;
    end
    r.zero = (r.data == '0);
    r.ovf  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    return r;
  endfunction

  function automatic rsp_t got_rsp();
    return {rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_ovf};
  endfunction

  // Expected {req1_ready, req0_ready} from the current inputs and model state.
  function automatic logic [1:0] exp_grant();
    if (rst || (m_v2 && !rsp_ready)) return 2'b00;
    if (req0_valid && req1_valid) return m_rr ? 2'b10 : 2'b01;
    return {req1_valid, req0_valid};
  endfunction

  task automatic model_reset();
    m_v1 = 1'b0; m_v2 = 1'b0; m_rr = 1'b0; m_p1 = '0; m_last = '0;
  endtask

  task automatic tick();
    logic [1:0] g;
    @(posedge clk);
    g = exp_grant();
    if (!(m_v2 && !rsp_ready)) begin
      if (m_v1) m_last = m_p1;
      m_v2 = m_v1;
      m_v1 = |g;
      if (g[0])      m_p1 = ref_op(1'b0, req0_sub, req0_a, req0_b);
      else if (g[1]) m_p1 = ref_op(1'b1, req1_sub, req1_a, req1_b);
      if (req0_valid && req1_valid && (g != 2'b00)) m_rr = ~g[1];
    end
    #1;
  endtask

  task automatic drive(input logic v0, input logic s0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic v1, input logic s1, input logic [W-1:0] a1, input logic [W-1:0] b1);
    req0_valid = v0; req0_sub = s0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_sub = s1; req1_a = a1; req1_b = b1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 0, 1, 2, 1, 0, 3, 4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b exp 00", {req1_ready, req0_ready});
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid);
    end
    checks++;
    if (got_rsp() !== rsp_t'('0)) begin
      errors++; $display("FAIL reset_rsp got %h exp 0", got_rsp());
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    drive(1, kALU_ADDER_OP_ADD, 5, 7, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready got %b exp 1", req0_ready);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_early got rsp_valid %b exp 0", rsp_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || got_rsp() !== mk(0, 12, 0, 0, 0)) begin
      errors++; $display("FAIL single_rsp got v=%b %h exp v=1 %h", rsp_valid, got_rsp(), mk(0, 12, 0, 0, 0));
    end
    tick();
  endtask

  task automatic test_alternate();
    rsp_t e;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1, kALU_ADDER_OP_SUB, 10, 3, 1, kALU_ADDER_OP_ADD, 32'h1000, 4);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (i < 4) begin
        checks++;
        if ({req1_ready, req0_ready} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL alt_grant cyc %0d got %b exp %b", i, {req1_ready, req0_ready},
                              (i % 2 == 1) ? 2'b10 : 2'b01);
        end
      end
      if (i >= 2) begin
        e = ((i - 2) % 2 == 1) ? mk(1, 32'h1004, 0, 0, 0) : mk(0, 7, 1, 0, 0);
        checks++;
        if (rsp_valid !== 1'b1 || got_rsp() !== e) begin
          errors++; $display("FAIL alt_rsp cyc %0d got v=%b %h exp %h", i, rsp_valid, got_rsp(), e);
        end
      end
      tick();
    end
  endtask

  task automatic test_boundary();
    logic         bs[4] = '{0, 0, 1, 1};
    logic [W-1:0] ba[4] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 3, 5};
    logic [W-1:0] bb[4] = '{1, 1, 5, 5};
    rsp_t         be[4];
    be[0] = mk(0, 32'h0, 1, 1, 0);
    be[1] = mk(0, 32'h8000_0000, 0, 0, 1);
    be[2] = mk(0, 32'hFFFF_FFFE, 0, 0, 0);
    be[3] = mk(0, 32'h0, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1, bs[i], ba[i], bb[i], 0, 0, 0, 0);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || got_rsp() !== be[i-2]) begin
          errors++; $display("FAIL boundary op %0d got v=%b %h exp %h", i - 2, rsp_valid, got_rsp(), be[i-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    rsp_t ea, eb;
    ea = mk(0, 123, 0, 0, 0);
    eb = mk(1, 42, 1, 0, 0);
    rsp_ready = 1'b1;
    drive(1, kALU_ADDER_OP_ADD, 100, 23, 0, 0, 0, 0);
    @(negedge clk); tick();
    drive(0, 0, 0, 0, 1, kALU_ADDER_OP_SUB, 50, 8);
    @(negedge clk); tick();
    drive(1, kALU_ADDER_OP_ADD, 1, 1, 1, kALU_ADDER_OP_ADD, 2, 2);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        errors++; $display("FAIL bp_ready cyc %0d got %b exp 00", k, {req1_ready, req0_ready});
      end
      checks++;
      if (rsp_valid !== 1'b1 || got_rsp() !== ea) begin
        errors++; $display("FAIL bp_hold cyc %0d got v=%b %h exp %h", k, rsp_valid, got_rsp(), ea);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || got_rsp() !== ea) begin
      errors++; $display("FAIL bp_drain0 got v=%b %h exp %h", rsp_valid, got_rsp(), ea);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || got_rsp() !== eb) begin
      errors++; $display("FAIL bp_drain1 got v=%b %h exp %h", rsp_valid, got_rsp(), eb);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || got_rsp() !== eb) begin
      errors++; $display("FAIL bp_empty got v=%b %h exp v=0 %h", rsp_valid, got_rsp(), eb);
    end
    tick();
  endtask

  task automatic test_async_reset();
    rsp_ready = 1'b1;
    drive(1, kALU_ADDER_OP_ADD, 9, 9, 1, kALU_ADDER_OP_ADD, 8, 8);
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== exp_grant()) begin
      errors++; $display("FAIL ar_pre_grant got %b exp %b", {req1_ready, req0_ready}, exp_grant());
    end
    tick();
    drive(0, 0, 0, 0, 1, kALU_ADDER_OP_SUB, 20, 1);
    @(negedge clk); tick();
    drive(1, kALU_ADDER_OP_ADD, 1, 1, 1, kALU_ADDER_OP_ADD, 2, 2);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || got_rsp() !== mk(0, 18, 0, 0, 0)) begin
      errors++; $display("FAIL ar_inflight got v=%b %h exp %h", rsp_valid, got_rsp(), mk(0, 18, 0, 0, 0));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready, rsp_valid} !== 3'b000 || got_rsp() !== rsp_t'('0)) begin
      errors++; $display("FAIL ar_outputs got rdy=%b v=%b %h exp all 0", {req1_ready, req0_ready}, rsp_valid, got_rsp());
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL ar_stale cyc %0d got rsp_valid %b exp 0", k, rsp_valid);
      end
      tick();
    end
    drive(1, kALU_ADDER_OP_ADD, 30, 12, 1, kALU_ADDER_OP_ADD, 40, 2);
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL ar_first_grant got %b exp 01", {req1_ready, req0_ready});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || got_rsp() !== mk(0, 42, 0, 0, 0)) begin
      errors++; $display("FAIL ar_post_rsp got v=%b %h exp %h", rsp_valid, got_rsp(), mk(0, 42, 0, 0, 0));
    end
    tick();
  endtask

  task automatic test_fixed_prio();
    drive(0, kALU_ADDER_OP_ADD, 0, 0, 0, kALU_ADDER_OP_ADD, 0, 0);
    fp0_valid = 1'b1; fp1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req0_a = $urandom(); req0_b = $urandom(); req1_a = $urandom(); req1_b = $urandom();
      @(negedge clk);
      checks++;
      if ({fp1_ready, fp0_ready} !== 2'b01) begin
        errors++; $display("FAIL fp_prio cyc %0d got %b exp 01", k, {fp1_ready, fp0_ready});
      end
      tick();
    end
    fp0_valid = 1'b0;
    req1_a = 32'd77; req1_b = 32'd3;
    @(negedge clk);
    checks++;
    if (fp1_ready !== 1'b1) begin
      errors++; $display("FAIL fp_req1_grant got %b exp 1", fp1_ready);
    end
    tick();
    fp1_valid = 1'b0;
    @(negedge clk); tick();
    @(negedge clk);
    checks++;
    if (fp_rsp_valid !== 1'b1 || fp_rsp_id !== 1'b1 || fp_rsp_data !== 32'd80) begin
      errors++; $display("FAIL fp_rsp got v=%b id=%b d=%h exp v=1 id=1 d=50", fp_rsp_valid, fp_rsp_id, fp_rsp_data);
    end
    tick();
  endtask

  task automatic test_random();
    logic [1:0] g;
    logic hold0 = 1'b0, hold1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold0) begin
        req0_valid = ($urandom_range(0, 2) != 0); req0_sub = $urandom_range(0, 1);
        req0_a = pick(); req0_b = pick();
      end
      if (!hold1) begin
        req1_valid = ($urandom_range(0, 2) != 0); req1_sub = $urandom_range(0, 1);
        req1_a = pick(); req1_b = pick();
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      g = exp_grant();
      checks++;
      if ({req1_ready, req0_ready} !== g) begin
        errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, {req1_ready, req0_ready}, g);
      end
      checks++;
      if (rsp_valid !== m_v2) begin
        errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, rsp_valid, m_v2);
      end
      checks++;
      if (got_rsp() !== m_last) begin
        errors++; $display("FAIL rnd_rsp cyc %0d got %h exp %h", c, got_rsp(), m_last);
      end
      hold0 = req0_valid && !g[0];
      hold1 = req1_valid && !g[1];
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rsp_ready = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_boundary();
    test_backpressure();
    test_async_reset();
    test_fixed_prio();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
